// File: rtl/oc8051_pmem_arb.sv
// Program-memory arbiter: shares the oc8051_rom port between instruction fetch (3 bytes)
// and MOVC (1 byte); external addresses are read byte-serially. Option: OC8051_PMEM_RR_EN.
module oc8051_pmem_arb #(
    parameter int unsigned EXT_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        mc_req,
    input  logic [15:0] mc_addr,
    output logic        if_ack,
    output logic        mc_ack,
    output logic [7:0]  rd_data1,
    output logic [7:0]  rd_data2,
    output logic [7:0]  rd_data3,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    input  logic [7:0]  ext_data,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_INT, S_EXT} state_t;

    localparam logic [3:0] WAIT_LD = 4'(EXT_WAIT);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner_mc;
    logic [15:0] r_addr_q;
    logic [1:0]  r_bidx;
    logic [3:0]  r_wcnt;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [7:0]  r_rd1;
    logic [7:0]  r_rd2;
    logic [7:0]  r_rd3;
    logic        r_if_ack;
    logic        r_mc_ack;

    logic        w_if_eff;
    logic        w_mc_eff;
    logic        w_grant_any;
    logic        w_grant_mc;
    logic        w_last_byte;

    // A requester's own ack masks its still-held request for that cycle.
    assign w_if_eff    = if_req & ~r_if_ack;
    assign w_mc_eff    = mc_req & ~r_mc_ack;
    assign w_grant_any = w_if_eff | w_mc_eff;

`ifdef OC8051_PMEM_RR_EN
    logic r_last_mc;  // 0 = IF served last

    assign w_grant_mc = w_mc_eff & (~w_if_eff | ~r_last_mc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mc <= 1'b0;
        end else if (r_state == S_IDLE && w_grant_any) begin
            r_last_mc <= w_grant_mc;
        end
    end
`else
    assign w_grant_mc = w_mc_eff;
`endif

    assign w_last_byte = r_owner_mc ? (r_bidx == 2'd0) : (r_bidx == 2'd2);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_any) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = rom_ea_int ? S_INT : S_EXT;
            S_INT:   w_state_next = S_IDLE;
            S_EXT:   if (r_wcnt == 4'd0 && w_last_byte) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner_mc <= 1'b0;
            r_addr_q   <= 16'h0000;
            r_bidx     <= 2'd0;
            r_wcnt     <= 4'd0;
            r_byte0    <= 8'h00;
            r_byte1    <= 8'h00;
            r_rd1      <= 8'h00;
            r_rd2      <= 8'h00;
            r_rd3      <= 8'h00;
            r_if_ack   <= 1'b0;
            r_mc_ack   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_if_ack <= 1'b0;
            r_mc_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner_mc <= w_grant_mc;
                        r_addr_q   <= w_grant_mc ? mc_addr : if_addr;
                    end
                end
                S_ISSUE: begin
                    r_bidx <= 2'd0;
                    r_wcnt <= WAIT_LD;
                end
                S_INT: begin
                    r_rd1    <= rom_data1;
                    r_rd2    <= r_owner_mc ? 8'h00 : rom_data2;
                    r_rd3    <= r_owner_mc ? 8'h00 : rom_data3;
                    r_if_ack <= ~r_owner_mc;
                    r_mc_ack <= r_owner_mc;
                end
                S_EXT: begin
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end else if (w_last_byte) begin
                        // Publish all bytes at once so rd_data only changes with an ack.
                        r_rd1    <= r_owner_mc ? ext_data : r_byte0;
                        r_rd2    <= r_owner_mc ? 8'h00 : r_byte1;
                        r_rd3    <= r_owner_mc ? 8'h00 : ext_data;
                        r_if_ack <= ~r_owner_mc;
                        r_mc_ack <= r_owner_mc;
                        r_bidx   <= 2'd0;
                    end else begin
                        if (r_bidx == 2'd0) r_byte0 <= ext_data;
                        else                r_byte1 <= ext_data;
                        r_bidx <= r_bidx + 2'd1;
                        r_wcnt <= WAIT_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_ack   = r_if_ack;
    assign mc_ack   = r_mc_ack;
    assign rd_data1 = r_rd1;
    assign rd_data2 = r_rd2;
    assign rd_data3 = r_rd3;
    assign rom_addr = r_addr_q;
    assign ext_addr = r_addr_q + {14'd0, r_bidx};
    assign ext_rd   = (r_state == S_EXT);
    assign busy     = (r_state != S_IDLE);

endmodule
